// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Contents:
//   ALUOP_*    two-bit ALU operation classes produced by the decoder
//   OP_*       primary opcode field values (instr[31:26])
//   ctl_t      decoded control bundle carried from ID into EX
//   CTL_BUBBLE all-zero control bundle used for inserted bubbles
package cpu_pkg;

    // ALU operation classes
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_IMM = 2'b11;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control bundle latched into EX (SignZero is consumed in ID and not carried)
    typedef struct packed {
        logic [1:0] alu_op;
        logic       jump;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       memto_reg;
        logic       alu_src;
        logic       reg_dst;
    } ctl_t;

    // A bubble must not write registers or memory, nor redirect the PC
    localparam ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary.
// A load in EX whose destination (rt) is read by the instruction in ID cannot
// forward in time, so the ID instruction must wait one cycle.
// Ports:
//   ex_MemRead  in  1       EX stage holds a load
//   ex_rt       in  REG_AW  load destination register
//   id_rs       in  REG_AW  ID source specifier rs
//   id_rt       in  REG_AW  ID source specifier rt
//   flush_i     in  1       ID instruction is being squashed
//   stall_o     out 1       hold PC and IF/ID this cycle
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_MemRead,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              flush_i,
    output logic              stall_o
);

    logic w_rt_nonzero;
    logic w_match;
    logic w_hazard;

    // $zero is never a real dependence
    assign w_rt_nonzero = |ex_rt;

    // Both specifiers are compared regardless of whether the ID instruction
    // actually reads them; the occasional extra stall is accepted.
    assign w_match  = (ex_rt == id_rs) | (ex_rt == id_rt);
    assign w_hazard = ex_MemRead & w_rt_nonzero & w_match;

    // A squashed instruction never needs to wait, and the PC must follow the redirect
    assign stall_o = w_hazard & ~flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Latches decoded controls, operands, extended immediate and register
// specifiers; inserts a bubble on a load-use hazard or a flush request.
// Optional feature macro: HAZARD_STATS_EN (adds stall_cnt / flush_cnt).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_<ctl>, id_ALUOp         decoded controls from ID
//   id_SignZero                1 = zero-extend immediate, 0 = sign-extend
//   id_pc4, id_rdata1/2        PC+4 and register operands (DATA_W)
//   id_imm                     raw 16-bit immediate
//   id_rs, id_rt, id_rd        register specifiers (REG_AW)
//   flush_i                    squash the ID instruction
//   stall_o                    combinational hold for PC and IF/ID
//   ex_*                       registered copies, ex_imm extended to DATA_W
//   ex_valid                   1 = real instruction in EX, 0 = bubble
//   stall_cnt, flush_cnt       (HAZARD_STATS_EN only) wrapping event counters
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              id_Jump,
    input  logic              id_SignZero,
    input  logic [1:0]        id_ALUOp,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic              ex_Jump,
    output logic [1:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    ctl_t              r_ctl;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic              r_valid;

    ctl_t              w_ctl_in;
    logic              w_fill;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_stall;
    logic              w_bubble;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_MemRead (r_ctl.mem_read),
        .ex_rt      (r_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .flush_i    (flush_i),
        .stall_o    (w_stall)
    );

    assign stall_o = w_stall;

    // Flush takes priority over stall; both load the same bubble
    assign w_bubble = flush_i | w_stall;

    // ------------------------------------------------------------------
    // Control bundle and immediate extension
    // ------------------------------------------------------------------
    always_comb begin
        w_ctl_in           = CTL_BUBBLE;
        w_ctl_in.alu_op    = id_ALUOp;
        w_ctl_in.jump      = id_Jump;
        w_ctl_in.branch    = id_Branch;
        w_ctl_in.mem_write = id_MemWrite;
        w_ctl_in.mem_read  = id_MemRead;
        w_ctl_in.reg_write = id_RegWrite;
        w_ctl_in.memto_reg = id_MemtoReg;
        w_ctl_in.alu_src   = id_ALUSrc;
        w_ctl_in.reg_dst   = id_RegDst;
    end

    // Fill bit is the immediate sign only when sign extension is requested
    assign w_fill    = ~id_SignZero & id_imm[15];
    assign w_imm_ext = {{(DATA_W-16){w_fill}}, id_imm};

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl    <= CTL_BUBBLE;
            r_pc4    <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
        end else if (w_bubble) begin
            // Data fields are cleared too so a bubble looks the same every time
            r_ctl    <= CTL_BUBBLE;
            r_pc4    <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_ctl    <= w_ctl_in;
            r_pc4    <= id_pc4;
            r_rdata1 <= id_rdata1;
            r_rdata2 <= id_rdata2;
            r_imm    <= w_imm_ext;
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_valid  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_RegDst   = r_ctl.reg_dst;
    assign ex_ALUSrc   = r_ctl.alu_src;
    assign ex_MemtoReg = r_ctl.memto_reg;
    assign ex_RegWrite = r_ctl.reg_write;
    assign ex_MemRead  = r_ctl.mem_read;
    assign ex_MemWrite = r_ctl.mem_write;
    assign ex_Branch   = r_ctl.branch;
    assign ex_Jump     = r_ctl.jump;
    assign ex_ALUOp    = r_ctl.alu_op;
    assign ex_pc4      = r_pc4;
    assign ex_rdata1   = r_rdata1;
    assign ex_rdata2   = r_rdata2;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_valid    = r_valid;

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Hazard statistics; both counters wrap modulo 2^32
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

    // Control vector bit positions used by the bench:
    // [9:8] ALUOp [7] Jump [6] Branch [5] MemWrite [4] MemRead
    // [3] RegWrite [2] MemtoReg [1] ALUSrc [0] RegDst
    localparam logic [9:0] C_LW  = 10'b00_0001_1110;
    localparam logic [9:0] C_ADD = 10'b10_0000_1001;

    logic        clk;
    logic        reset;
    logic [9:0]  id_ctl;
    logic        id_sz;
    logic [31:0] id_pc4, id_rd1, id_rd2;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;

    logic        stall_o;
    logic        ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
    logic        ex_MemWrite, ex_Branch, ex_Jump, ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    logic [9:0] ex_ctl;
    assign ex_ctl = {ex_ALUOp, ex_Jump, ex_Branch, ex_MemWrite, ex_MemRead,
                     ex_RegWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst};

    id_ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .id_RegDst   (id_ctl[0]),
        .id_ALUSrc   (id_ctl[1]),
        .id_MemtoReg (id_ctl[2]),
        .id_RegWrite (id_ctl[3]),
        .id_MemRead  (id_ctl[4]),
        .id_MemWrite (id_ctl[5]),
        .id_Branch   (id_ctl[6]),
        .id_Jump     (id_ctl[7]),
        .id_SignZero (id_sz),
        .id_ALUOp    (id_ctl[9:8]),
        .id_pc4      (id_pc4),
        .id_rdata1   (id_rd1),
        .id_rdata2   (id_rd2),
        .id_imm      (id_imm),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .flush_i     (flush),
        .stall_o     (stall_o),
        .ex_RegDst   (ex_RegDst),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_MemtoReg (ex_MemtoReg),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_Branch   (ex_Branch),
        .ex_Jump     (ex_Jump),
        .ex_ALUOp    (ex_ALUOp),
        .ex_pc4      (ex_pc4),
        .ex_rdata1   (ex_rdata1),
        .ex_rdata2   (ex_rdata2),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_valid    (ex_valid)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: what EX should hold
    logic [9:0]  m_ctl;
    logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_valid;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    task automatic model_clear();
        m_ctl = '0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_valid = 1'b0;
    endtask

    function automatic logic model_stall();
        // A load in EX targeting a non-zero register that ID names as a source
        return m_ctl[4] && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt) && !flush;
    endfunction

    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic sz);
        // Sign extension as arithmetic: negative halfwords lose 2^16
        if (sz || !imm[15]) return 32'(imm);
        return 32'(imm) - 32'h0001_0000;
    endfunction

    task automatic check_outputs();
        check_eq("ex_ctl", 64'(ex_ctl), 64'(m_ctl));
        check_eq("ex_pc4", 64'(ex_pc4), 64'(m_pc4));
        check_eq("ex_rdata1", 64'(ex_rdata1), 64'(m_rd1));
        check_eq("ex_rdata2", 64'(ex_rdata2), 64'(m_rd2));
        check_eq("ex_imm", 64'(ex_imm), 64'(m_imm));
        check_eq("ex_rs", 64'(ex_rs), 64'(m_rs));
        check_eq("ex_rt", 64'(ex_rt), 64'(m_rt));
        check_eq("ex_rd", 64'(ex_rd), 64'(m_rd));
        check_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
`ifdef HAZARD_STATS_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`endif
    endtask

    task automatic drive(input logic [9:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl);
        id_ctl = ctl; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
        id_imm = 16'($urandom); id_sz = 1'($urandom);
    endtask

    // Check stall before the edge, advance the model across it, check after it
    task automatic step();
        logic st;
        #1;
        st = model_stall();
        check_eq("stall_o", 64'(stall_o), 64'(st));
        @(posedge clk);
        if (st) m_stall_cnt = m_stall_cnt + 1;
        if (flush) m_flush_cnt = m_flush_cnt + 1;
        if (flush || st) begin
            model_clear();
        end else begin
            m_ctl = id_ctl; m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2;
            m_imm = model_ext(id_imm, id_sz);
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_valid = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // T1: reset with busy inputs
        reset = 1'b1;
        drive(10'h3FF, 5'd9, 5'd10, 5'd11, 1'b0);
        model_clear();
        m_stall_cnt = '0; m_flush_cnt = '0;
        #2;
        check_outputs();
        check_eq("t1_stall", 64'(stall_o), 64'd0);
        reset = 1'b0;
        step();
        check_eq("t1_valid", 64'(ex_valid), 64'd1);

        // T2: immediate extension
        drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        id_imm = 16'h8001; id_sz = 1'b0;
        step();
        check_eq("t2_sext", 64'(ex_imm), 64'h0000_0000_FFFF_8001);
        drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        id_imm = 16'h8001; id_sz = 1'b1;
        step();
        check_eq("t2_zext", 64'(ex_imm), 64'h0000_0000_0000_8001);

        // T3: load-use stall for exactly one cycle
        drive(C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        step();
        drive(C_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        check_eq("t3_stall", 64'(stall_o), 64'd1);
        step();
        check_eq("t3_bubble_valid", 64'(ex_valid), 64'd0);
        check_eq("t3_bubble_regwr", 64'(ex_RegWrite), 64'd0);
        check_eq("t3_bubble_memwr", 64'(ex_MemWrite), 64'd0);
        step();
        check_eq("t3_add_valid", 64'(ex_valid), 64'd1);
        check_eq("t3_add_rs", 64'(ex_rs), 64'd5);

        // T4: no false hazards
        drive(C_LW, 5'd2, 5'd0, 5'd0, 1'b0);
        step();
        drive(C_ADD, 5'd0, 5'd0, 5'd1, 1'b0);
        #1;
        check_eq("t4_rt0", 64'(stall_o), 64'd0);
        step();
        drive(C_LW, 5'd2, 5'd7, 5'd0, 1'b0);
        step();
        drive(C_ADD, 5'd3, 5'd4, 5'd1, 1'b0);
        #1;
        check_eq("t4_nodep", 64'(stall_o), 64'd0);
        step();

        // T5: flush overrides the hazard
        drive(C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        step();
        drive(C_ADD, 5'd5, 5'd6, 5'd7, 1'b1);
        #1;
        check_eq("t5_stall", 64'(stall_o), 64'd0);
        step();
        check_eq("t5_valid", 64'(ex_valid), 64'd0);

        // T6: reset in the middle of a stall
        drive(C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        step();
        drive(C_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        check_eq("t6_stall_pre", 64'(stall_o), 64'd1);
        reset = 1'b1;
        #1;
        model_clear();
        m_stall_cnt = '0; m_flush_cnt = '0;
        check_outputs();
        check_eq("t6_stall_rst", 64'(stall_o), 64'd0);
        reset = 1'b0;
        step();
        check_eq("t6_valid", 64'(ex_valid), 64'd1);

        // Randomized traffic with dense register reuse to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = 10'($urandom);
            c[4] = ($urandom_range(0, 9) < 4);
            drive(c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
